// File: rtl/cred_rom_arbiter.sv
// Round-robin arbiter that lets two access controllers share one user/password ROM pair,
// scanning it linearly for a credential match and locking out repeat offenders.
module cred_rom_arbiter #(
  parameter int DEPTH    = 8,
  parameter int ROM_LAT  = 1,
  parameter int MAX_FAIL = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [15:0] user0,
  input  logic [19:0] pass0,
  input  logic        req1,
  input  logic [15:0] user1,
  input  logic [19:0] pass1,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_user,
  input  logic [19:0] rom_pass,
  output logic        busy,
  output logic        grant0,
  output logic        grant1,
  output logic        done0,
  output logic        done1,
  output logic        match,
  output logic [7:0]  slot,
  output logic        locked0,
  output logic        locked1
);

  typedef enum logic [1:0] {IDLE, FETCH, COMPARE, DONE} state_t;

  state_t      state_q;
  logic        owner_q;
  logic        last_q;
  logic [15:0] user_q;
  logic [19:0] pass_q;
  logic [7:0]  addr_q;
  logic [1:0]  cnt_q;
  logic        busy_q;
  logic        grant0_q;
  logic        grant1_q;
  logic        done0_q;
  logic        done1_q;
  logic        match_q;
  logic [7:0]  slot_q;
  logic        locked0_q;
  logic        locked1_q;
  logic [2:0]  fail0_q;
  logic [2:0]  fail1_q;

  logic        pick1;
  logic [1:0]  cnt_d;
  logic [2:0]  failSel;
  logic [2:0]  fail_d;
  logic        hit;

  // pick1 favours whichever requester was not granted last when both ask
  always_comb begin
    pick1   = req1 & (~req0 | ~last_q);
    cnt_d   = cnt_q + 2'd1;
    failSel = owner_q ? fail1_q : fail0_q;
    fail_d  = (failSel >= 3'(MAX_FAIL)) ? failSel : failSel + 3'd1;
    hit     = (user_q == rom_user) && (pass_q == rom_pass);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      user_q    <= '0;
      pass_q    <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      grant0_q  <= 1'b0;
      grant1_q  <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      match_q   <= 1'b0;
      slot_q    <= '0;
      locked0_q <= 1'b0;
      locked1_q <= 1'b0;
      fail0_q   <= '0;
      fail1_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 | req1) begin
            owner_q  <= pick1;
            last_q   <= pick1;
            user_q   <= pick1 ? user1 : user0;
            pass_q   <= pick1 ? pass1 : pass0;
            addr_q   <= '0;
            cnt_q    <= '0;
            grant0_q <= ~pick1;
            grant1_q <= pick1;
            busy_q   <= 1'b1;
            match_q  <= 1'b0;
            slot_q   <= '0;
            state_q  <= (pick1 ? locked1_q : locked0_q) ? DONE : FETCH;
          end
        end
        FETCH: begin
          cnt_q <= cnt_d;
          if (cnt_d == 2'(ROM_LAT)) state_q <= COMPARE;
        end
        COMPARE: begin
          cnt_q <= '0;
          if (hit) begin
            match_q <= 1'b1;
            slot_q  <= addr_q;
            state_q <= DONE;
          end else if (addr_q == 8'(DEPTH - 1)) begin
            match_q <= 1'b0;
            slot_q  <= '0;
            state_q <= DONE;
          end else begin
            addr_q  <= addr_q + 8'd1;
            state_q <= FETCH;
          end
        end
        DONE: begin
          // One settle cycle, then the done pulse, then release back to IDLE
          if (done0_q | done1_q) begin
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            grant0_q <= 1'b0;
            grant1_q <= 1'b0;
            busy_q   <= 1'b0;
            match_q  <= 1'b0;
            slot_q   <= '0;
            state_q  <= IDLE;
          end else if (cnt_q == 2'd0) begin
            cnt_q <= 2'd1;
          end else begin
            done0_q <= ~owner_q;
            done1_q <= owner_q;
            if (owner_q) begin
              fail1_q <= match_q ? 3'd0 : fail_d;
              if (!match_q && fail_d == 3'(MAX_FAIL)) locked1_q <= 1'b1;
            end else begin
              fail0_q <= match_q ? 3'd0 : fail_d;
              if (!match_q && fail_d == 3'(MAX_FAIL)) locked0_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr = addr_q;
  assign busy     = busy_q;
  assign grant0   = grant0_q;
  assign grant1   = grant1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign match    = match_q;
  assign slot     = slot_q;
  assign locked0  = locked0_q;
  assign locked1  = locked1_q;

endmodule

// File: tb/tb_cred_rom_arbiter.sv
// Directed bench for cred_rom_arbiter: one instance with ROM_LAT=1, one with ROM_LAT=3,
// each backed by a pipelined ROM model whose slot 3 holds 1234/56789.
module tb_cred_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [15:0] user0, user1;
  logic [19:0] pass0, pass1;
  logic [7:0]  rom_addr;
  logic [15:0] rom_user;
  logic [19:0] rom_pass;
  logic        busy, grant0, grant1, done0, done1, match, locked0, locked1;
  logic [7:0]  slot;

  logic        reqB;
  logic        reqBIdle;
  logic [15:0] userB;
  logic [19:0] passB;
  logic [7:0]  romAddrB;
  logic [15:0] romUserB, romUserB1, romUserB2;
  logic [19:0] romPassB, romPassB1, romPassB2;
  logic        busyB, grant0B, grant1B, done0B, done1B, matchB, locked0B, locked1B;
  logic [7:0]  slotB;

  int checks = 0;
  int failures = 0;
  int overlapErr = 0;

  always #5 clk = ~clk;

  cred_rom_arbiter #(.DEPTH(8), .ROM_LAT(1), .MAX_FAIL(3)) u_dut (
    .clk(clk), .rst(rst),
    .req0(req0), .user0(user0), .pass0(pass0),
    .req1(req1), .user1(user1), .pass1(pass1),
    .rom_addr(rom_addr), .rom_user(rom_user), .rom_pass(rom_pass),
    .busy(busy), .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
    .match(match), .slot(slot), .locked0(locked0), .locked1(locked1)
  );

  cred_rom_arbiter #(.DEPTH(8), .ROM_LAT(3), .MAX_FAIL(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0(reqB), .user0(userB), .pass0(passB),
    .req1(reqBIdle), .user1(16'h0), .pass1(20'h0),
    .rom_addr(romAddrB), .rom_user(romUserB), .rom_pass(romPassB),
    .busy(busyB), .grant0(grant0B), .grant1(grant1B), .done0(done0B), .done1(done1B),
    .match(matchB), .slot(slotB), .locked0(locked0B), .locked1(locked1B)
  );

  function automatic logic [15:0] romUserOf(input logic [7:0] a);
    return (a == 8'd3) ? 16'h1234 : 16'h1000 + {8'h00, a};
  endfunction

  function automatic logic [19:0] romPassOf(input logic [7:0] a);
    return (a == 8'd3) ? 20'h56789 : 20'h20000 + {12'h000, a};
  endfunction

  // ROM models: one register stage for u_dut, three for u_dut3
  always_ff @(posedge clk) begin
    rom_user  <= romUserOf(rom_addr);
    rom_pass  <= romPassOf(rom_addr);
    romUserB1 <= romUserOf(romAddrB);
    romPassB1 <= romPassOf(romAddrB);
    romUserB2 <= romUserB1;
    romPassB2 <= romPassB1;
    romUserB  <= romUserB2;
    romPassB  <= romPassB2;
  end

  always @(negedge clk) begin
    if ((grant0 && grant1) || (done0 && done1)) overlapErr++;
  end

  task automatic applyReset();
    req0 = 0; req1 = 0; reqB = 0; reqBIdle = 0;
    user0 = 0; pass0 = 0; user1 = 0; pass1 = 0; userB = 0; passB = 0;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

  // Drives one lookup on u_dut and reports grant wait, latency and the done-cycle result
  task automatic runLookup(input bit side, input logic [15:0] u, input logic [19:0] p,
                           output int gw, output int lat, output logic m,
                           output logic [7:0] s, output logic [7:0] a, output logic doneAfter);
    bit gotGrant;
    gw = -1; lat = -1; m = 1'bx; s = 8'hxx; a = 8'hxx; doneAfter = 1'bx;
    gotGrant = 0;
    if (side) begin req1 = 1; user1 = u; pass1 = p; end
    else begin req0 = 1; user0 = u; pass0 = p; end
    for (int i = 1; i <= 20 && !gotGrant; i++) begin
      @(negedge clk);
      if ((side ? grant1 : grant0) === 1'b1) begin gotGrant = 1; gw = i; end
    end
    if (gotGrant) begin
      for (int n = 1; n <= 100 && lat < 0; n++) begin
        @(negedge clk);
        if ((side ? done1 : done0) === 1'b1) begin
          lat = n; m = match; s = slot; a = rom_addr;
          if (side) req1 = 0; else req0 = 0;
          @(negedge clk);
          doneAfter = side ? done1 : done0;
        end
      end
    end
    req0 = 0; req1 = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    applyReset();
    checks++;
    if ({busy, grant0, grant1, done0, done1, match, slot, locked0, locked1, rom_addr} !== 24'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h want=0",
               {busy, grant0, grant1, done0, done1, match, slot, locked0, locked1, rom_addr});
    end
  endtask

  task automatic test_match_slot3();
    int gw, lat; logic m, da; logic [7:0] s, a;
    runLookup(1'b0, 16'h1234, 20'h56789, gw, lat, m, s, a, da);
    checks++; if (gw !== 1) begin failures++; $display("[TB] FAIL m3_grant_wait got=%0d want=1", gw); end
    checks++; if (lat !== 10) begin failures++; $display("[TB] FAIL m3_latency got=%0d want=10", lat); end
    checks++; if (m !== 1'b1) begin failures++; $display("[TB] FAIL m3_match got=%b want=1", m); end
    checks++; if (s !== 8'd3) begin failures++; $display("[TB] FAIL m3_slot got=%0d want=3", s); end
    checks++; if (da !== 1'b0) begin failures++; $display("[TB] FAIL m3_done_width got=%b want=0", da); end
    checks++; if (locked0 !== 1'b0) begin failures++; $display("[TB] FAIL m3_locked0 got=%b want=0", locked0); end
  endtask

  task automatic test_both_requests();
    int gap, lat1; logic m1; logic [7:0] s1;
    applyReset();
    req0 = 1; user0 = 16'h1234; pass0 = 20'h56789;
    req1 = 1; user1 = 16'h1005; pass1 = 20'h20005;
    @(negedge clk);
    checks++;
    if ({grant0, grant1} !== 2'b10) begin
      failures++; $display("[TB] FAIL both_first_grant got=%b want=10", {grant0, grant1});
    end
    for (int i = 0; i < 40 && done0 !== 1'b1; i++) @(negedge clk);
    req0 = 0;
    gap = -1;
    for (int i = 1; i <= 10 && gap < 0; i++) begin
      @(negedge clk);
      if (grant1 === 1'b1) gap = i;
    end
    checks++; if (gap !== 2) begin failures++; $display("[TB] FAIL both_grant1_gap got=%0d want=2", gap); end
    lat1 = -1; m1 = 1'bx; s1 = 8'hxx;
    for (int n = 1; n <= 40 && lat1 < 0; n++) begin
      @(negedge clk);
      if (done1 === 1'b1) begin lat1 = n; m1 = match; s1 = slot; req1 = 0; end
    end
    checks++; if (lat1 !== 14) begin failures++; $display("[TB] FAIL both_p1_latency got=%0d want=14", lat1); end
    checks++; if ({m1, s1} !== {1'b1, 8'd5}) begin failures++; $display("[TB] FAIL both_p1_result got=%b/%0d want=1/5", m1, s1); end
    repeat (2) @(negedge clk);
    checks++; if (overlapErr !== 0) begin failures++; $display("[TB] FAIL grant_overlap got=%0d want=0", overlapErr); end
  endtask

  task automatic test_full_miss();
    int gw, lat; logic m, da; logic [7:0] s, a;
    runLookup(1'b1, 16'h1234, 20'h00000, gw, lat, m, s, a, da);
    checks++; if (lat !== 18) begin failures++; $display("[TB] FAIL miss_latency got=%0d want=18", lat); end
    checks++; if ({m, s} !== 9'd0) begin failures++; $display("[TB] FAIL miss_result got=%b/%0d want=0/0", m, s); end
    checks++; if (a !== 8'd7) begin failures++; $display("[TB] FAIL miss_last_addr got=%0d want=7", a); end
  endtask

  task automatic test_lockout();
    int gw, lat; logic m, da; logic [7:0] s, a;
    applyReset();
    for (int k = 1; k <= 3; k++) begin
      runLookup(1'b0, 16'hdead, 20'h00000, gw, lat, m, s, a, da);
      checks++;
      if (locked0 !== (k == 3)) begin
        failures++; $display("[TB] FAIL lock_after_%0d got=%b want=%b", k, locked0, (k == 3));
      end
    end
    runLookup(1'b0, 16'h1234, 20'h56789, gw, lat, m, s, a, da);
    checks++; if (lat !== 2) begin failures++; $display("[TB] FAIL locked_latency got=%0d want=2", lat); end
    checks++; if (m !== 1'b0) begin failures++; $display("[TB] FAIL locked_match got=%b want=0", m); end
    checks++; if (a !== 8'd0) begin failures++; $display("[TB] FAIL locked_addr got=%0d want=0", a); end
    checks++; if (locked1 !== 1'b0) begin failures++; $display("[TB] FAIL locked1_clear got=%b want=0", locked1); end
  endtask

  task automatic test_reset_mid_scan();
    int gw, lat, stray; logic m, da; logic [7:0] s, a;
    req1 = 1; user1 = 16'h1234; pass1 = 20'h00000;
    for (int i = 0; i < 10 && grant1 !== 1'b1; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++;
    if ({busy, grant0, grant1, done0, done1, match, slot, locked0, locked1, rom_addr} !== 24'd0) begin
      failures++;
      $display("[TB] FAIL midrst_outputs got=%h want=0",
               {busy, grant0, grant1, done0, done1, match, slot, locked0, locked1, rom_addr});
    end
    rst = 0; req1 = 0;
    stray = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done0 || done1) stray++;
    end
    checks++; if (stray !== 0) begin failures++; $display("[TB] FAIL midrst_stray_done got=%0d want=0", stray); end
    runLookup(1'b0, 16'h1234, 20'h56789, gw, lat, m, s, a, da);
    checks++; if ({lat, m, s} !== {32'd10, 1'b1, 8'd3}) begin
      failures++; $display("[TB] FAIL midrst_relookup got=%0d/%b/%0d want=10/1/3", lat, m, s);
    end
  endtask

  task automatic test_rom_lat3();
    int lat; logic m; logic [7:0] s;
    reqB = 1; userB = 16'h1000; passB = 20'h20000;
    for (int i = 0; i < 10 && grant0B !== 1'b1; i++) @(negedge clk);
    lat = -1; m = 1'bx; s = 8'hxx;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      if (n == 2) reqB = 0;
      if (done0B === 1'b1) begin lat = n; m = matchB; s = slotB; end
    end
    checks++; if (lat !== 6) begin failures++; $display("[TB] FAIL lat3_latency got=%0d want=6", lat); end
    checks++; if ({m, s} !== {1'b1, 8'd0}) begin failures++; $display("[TB] FAIL lat3_result got=%b/%0d want=1/0", m, s); end
  endtask

  initial begin
    test_reset();
    test_match_slot3();
    test_both_requests();
    test_full_miss();
    test_lockout();
    test_reset_mid_scan();
    test_rom_lat3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
